video_timing_gen: RTL and testbench

- Parametrised successor to the fixed-mode video position/sync generator.
- Produces pixel coordinates, draw-valid, blanking flags, sync pulses and frame/line markers for any raster timing, with selectable sync polarity.
- Adds a frame counter and start-of-line/start-of-frame strobes.
- Sits between the video PLL and the pixel renderer in each display top level.

---
 rtl/video_timing_gen.sv | 150 +++++++++++++++
 tb/tb_video_timing_gen.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, blanking, syncs,
// line/frame strobes and a completed-frame counter, all registered one clock
// after the internal (hc, vc) counter state.
// Optional colour-bar test pattern when VIDEO_TIMING_TEST_PATTERN_EN is defined;
// otherwise pattern_rgb is tied to zero.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FRONT   = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BACK    = 88,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 13,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BACK    = 29,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned POS_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             valid_draw,
    output logic             h_blank,
    output logic             v_blank,
    output logic [POS_W-1:0] h_pos,
    output logic [POS_W-1:0] v_pos,
    output logic             disp_hsync,
    output logic             disp_vsync,
    output logic             line_start,
    output logic             frame_start,
    output logic [15:0]      frame_count,
    output logic [23:0]      pattern_rgb
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FRONT + V_SYNC;

    localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST  = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic [POS_W-1:0] hc;
    logic [POS_W-1:0] vc;

    logic dec_h_blank;
    logic dec_v_blank;
    logic dec_valid;
    logic dec_hsync;
    logic dec_vsync;
    logic dec_line_start;
    logic dec_frame_start;
    logic h_last;
    logic v_last;

    // Region decode of the current (pre-increment) counter state.
    always_comb begin
        dec_h_blank     = 32'(hc) >= H_ACTIVE;
        dec_v_blank     = 32'(vc) >= V_ACTIVE;
        dec_valid       = !dec_h_blank && !dec_v_blank;
        dec_hsync       = (32'(hc) >= H_SYNC_BEG) && (32'(hc) < H_SYNC_END);
        dec_vsync       = (32'(vc) >= V_SYNC_BEG) && (32'(vc) < V_SYNC_END);
        dec_line_start  = (hc == '0);
        dec_frame_start = (hc == '0) && (vc == '0);
        h_last          = (hc == H_LAST);
        v_last          = (vc == V_LAST);
    end

    // Raster counters and completed-frame counter; all hold while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else if (en) begin
            if (h_last) begin
                hc <= '0;
                if (v_last) begin
                    vc          <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    vc <= vc + POS_ONE;
                end
            end else begin
                hc <= hc + POS_ONE;
            end
        end
    end

    // Registered timing outputs; strobes and draw-valid drop while paused,
    // everything else keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_draw  <= 1'b0;
            h_blank     <= 1'b1;
            v_blank     <= 1'b1;
            h_pos       <= '0;
            v_pos       <= '0;
            disp_hsync  <= ~HSYNC_POL;
            disp_vsync  <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            valid_draw  <= dec_valid;
            h_blank     <= dec_h_blank;
            v_blank     <= dec_v_blank;
            h_pos       <= dec_h_blank ? '0 : hc;
            v_pos       <= dec_v_blank ? '0 : vc;
            disp_hsync  <= dec_hsync ? HSYNC_POL : ~HSYNC_POL;
            disp_vsync  <= dec_vsync ? VSYNC_POL : ~VSYNC_POL;
            line_start  <= dec_line_start;
            frame_start <= dec_frame_start;
        end else begin
            valid_draw  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] bar_rgb;

    // Bar colours follow the index bits: R on bar[1]=0, G on bar[2]=0, B on bar[0]=0.
    always_comb begin
        bar     = 3'((32'(hc) * 32'd8) / H_ACTIVE);
        bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        if ((bar == 3'd0) && frame_count[5]) begin
            bar_rgb = '0;
        end
    end

    // Pattern registered alongside valid_draw and blanked with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_rgb <= '0;
        end else if (en && dec_valid) begin
            pattern_rgb <= bar_rgb;
        end else begin
            pattern_rgb <= '0;
        end
    end
`else
    assign pattern_rgb = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen in the small raster mode
// (H 8/2/2/2, V 4/1/1/1). A behavioural model pushes expected outputs per
// driven cycle; a second instance checks inverted sync polarity and a third
// (H_ACTIVE=16) checks the colour-bar mapping over its first line.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic        v0, hb0, vb0, hs0, vs0, ls0, fs0;
    logic [3:0]  hp0, vp0;
    logic [15:0] fc0;
    logic [23:0] pat0;

    logic        v1, hb1, vb1, hs1, vs1, ls1, fs1;
    logic [3:0]  hp1, vp1;
    logic [15:0] fc1;
    logic [23:0] pat1;

    logic        v2, hb2, vb2, hs2, vs2, ls2, fs2;
    logic [4:0]  hp2, vp2;
    logic [15:0] fc2;
    logic [23:0] pat2;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .POS_W(4)
    ) dut0 (
        .clk(clk), .reset(rst), .en(en),
        .valid_draw(v0), .h_blank(hb0), .v_blank(vb0), .h_pos(hp0), .v_pos(vp0),
        .disp_hsync(hs0), .disp_vsync(vs0), .line_start(ls0), .frame_start(fs0),
        .frame_count(fc0), .pattern_rgb(pat0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .POS_W(4)
    ) dut1 (
        .clk(clk), .reset(rst), .en(en),
        .valid_draw(v1), .h_blank(hb1), .v_blank(vb1), .h_pos(hp1), .v_pos(vp1),
        .disp_hsync(hs1), .disp_vsync(vs1), .line_start(ls1), .frame_start(fs1),
        .frame_count(fc1), .pattern_rgb(pat1)
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .POS_W(5)
    ) dut2 (
        .clk(clk), .reset(rst), .en(en),
        .valid_draw(v2), .h_blank(hb2), .v_blank(vb2), .h_pos(hp2), .v_pos(vp2),
        .disp_hsync(hs2), .disp_vsync(vs2), .line_start(ls2), .frame_start(fs2),
        .frame_count(fc2), .pattern_rgb(pat2)
    );

    logic [23:0] colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        logic        valid, hblank, vblank, hs_act, vs_act, ls, fs;
        logic [3:0]  hpos, vpos;
        logic [15:0] fc;
        logic [23:0] pat;
    } out_t;

    typedef struct {
        logic        rst, en;
        logic        valid, hblank, hsync, ls, fs;
        logic [3:0]  hpos;
        logic        p_valid, p_hblank, p_ls, p_fs;
        logic [4:0]  p_hpos;
        logic [23:0] p_pat;
    } vec_t;

    out_t sb_q[$];
    out_t eo;
    int   mhc, mvc;
    logic [15:0] mfc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic e);
        int bar;
        if (r) begin
            mhc = 0; mvc = 0; mfc = '0;
            eo.valid = 0; eo.hblank = 1; eo.vblank = 1; eo.hs_act = 0; eo.vs_act = 0;
            eo.ls = 0; eo.fs = 0; eo.hpos = '0; eo.vpos = '0; eo.pat = '0;
        end else if (e) begin
            eo.hblank = (mhc >= HA);
            eo.vblank = (mvc >= VA);
            eo.valid  = !eo.hblank && !eo.vblank;
            eo.hpos   = eo.hblank ? 4'd0 : 4'(mhc);
            eo.vpos   = eo.vblank ? 4'd0 : 4'(mvc);
            eo.hs_act = (mhc >= HA + HF) && (mhc < HA + HF + HS);
            eo.vs_act = (mvc >= VA + VF) && (mvc < VA + VF + VS);
            eo.ls     = (mhc == 0);
            eo.fs     = (mhc == 0) && (mvc == 0);
            eo.pat    = '0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            if (eo.valid) begin
                bar    = mhc * 8 / HA;
                eo.pat = colors[bar];
                if (bar == 0 && mfc[5]) eo.pat = '0;
            end
`endif
            mhc++;
            if (mhc == HT) begin
                mhc = 0;
                mvc++;
                if (mvc == VT) begin
                    mvc = 0;
                    mfc = mfc + 16'd1;
                end
            end
        end else begin
            eo.valid = 0; eo.ls = 0; eo.fs = 0; eo.pat = '0;
        end
        eo.fc = mfc;
        sb_q.push_back(eo);
    endtask

    task automatic step(input logic r, input logic e);
        out_t ex;
        rst = r;
        en  = e;
        model_step(r, e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty t=%0t", $time);
        end else begin
            ex = sb_q.pop_front();
            chk("valid_draw", v0, ex.valid);
            chk("h_blank", hb0, ex.hblank);
            chk("v_blank", vb0, ex.vblank);
            chk("h_pos", hp0, ex.hpos);
            chk("v_pos", vp0, ex.vpos);
            chk("hsync_lo", hs0, !ex.hs_act);
            chk("vsync_lo", vs0, !ex.vs_act);
            chk("line_start", ls0, ex.ls);
            chk("frame_start", fs0, ex.fs);
            chk("frame_count", fc0, ex.fc);
            chk("pattern", pat0, ex.pat);
            chk("hsync_hi", hs1, ex.hs_act);
            chk("vsync_hi", vs1, ex.vs_act);
            chk("d1_misc", {v1, hb1, vb1, hp1, vp1, ls1, fs1},
                {ex.valid, ex.hblank, ex.vblank, ex.hpos, ex.vpos, ex.ls, ex.fs});
            chk("d1_fc_pat", {fc1, pat1}, {ex.fc, ex.pat});
        end
    endtask

    vec_t vecs [25];

    initial begin
        int   cnt, hs_cnt, hs_first, vb_cnt, vs_cnt, fs_extra, en_cnt;
        logic [15:0] fc_start;
        bit   found;

        // Table: 3 reset cycles then the first 22 enabled cycles.
        for (int i = 0; i < 3; i++) begin
            vecs[i] = '{rst: 1, en: 1, valid: 0, hblank: 1, hsync: 1, ls: 0, fs: 0,
                        hpos: 0, p_valid: 0, p_hblank: 1, p_ls: 0, p_fs: 0,
                        p_hpos: 0, p_pat: 0};
        end
        for (int i = 0; i < 22; i++) begin
            int h0;
            h0 = i % HT;
            vecs[i+3].rst      = 0;
            vecs[i+3].en       = 1;
            vecs[i+3].valid    = (h0 < 8);
            vecs[i+3].hblank   = (h0 >= 8);
            vecs[i+3].hsync    = !(h0 == 10 || h0 == 11);
            vecs[i+3].ls       = (h0 == 0);
            vecs[i+3].fs       = (i == 0);
            vecs[i+3].hpos     = (h0 < 8) ? 4'(h0) : 4'd0;
            vecs[i+3].p_valid  = (i < 16);
            vecs[i+3].p_hblank = (i >= 16);
            vecs[i+3].p_ls     = (i == 0);
            vecs[i+3].p_fs     = (i == 0);
            vecs[i+3].p_hpos   = (i < 16) ? 5'(i) : 5'd0;
            vecs[i+3].p_pat    = '0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
            if (i < 16) vecs[i+3].p_pat = colors[i/2];
`endif
        end

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].rst, vecs[i].en);
            chk("tv_valid", v0, vecs[i].valid);
            chk("tv_hblank", hb0, vecs[i].hblank);
            chk("tv_hsync", hs0, vecs[i].hsync);
            chk("tv_ls_fs", {ls0, fs0}, {vecs[i].ls, vecs[i].fs});
            chk("tv_hpos", hp0, vecs[i].hpos);
            chk("tv_p_valid", {v2, hb2}, {vecs[i].p_valid, vecs[i].p_hblank});
            chk("tv_p_ls_fs", {ls2, fs2}, {vecs[i].p_ls, vecs[i].p_fs});
            chk("tv_p_hpos", hp2, vecs[i].p_hpos);
            chk("tv_p_pat", pat2, vecs[i].p_pat);
            if (i < 3) chk("tv_vblank_rst", {vb0, vs0, vb2, vs2, hs2}, 5'b11111);
            if (i < 3) chk("tv_rst_counts", {vp0, fc0, vp2, fc2}, '0);
        end

        // One line: valid for 8 clocks, hsync at counts 10-11, line period 14.
        found = 0;
        for (int k = 0; k < LIMIT && !found; k++) begin
            step(0, 1);
            found = ls0;
        end
        chk("line_wait", found, 1);
        cnt = v0; hs_cnt = 0; hs_first = -1;
        for (int k = 1; k < HT; k++) begin
            step(0, 1);
            if (v0) begin
                cnt++;
                chk("line_hpos_seq", hp0, k);
            end
            if (!hs0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            chk("line_ls_gap", ls0, 0);
        end
        chk("line_valid_cnt", cnt, 8);
        chk("line_hsync_cnt", hs_cnt, 2);
        chk("line_hsync_first", hs_first, 10);
        step(0, 1);
        chk("line_period", ls0, 1);

        // One frame: v_blank 3 lines, vsync one line, frame period 98.
        found = 0;
        for (int k = 0; k < LIMIT && !found; k++) begin
            step(0, 1);
            found = fs0;
        end
        chk("frame_wait", found, 1);
        fc_start = fc0;
        vb_cnt = 0; vs_cnt = 0; fs_extra = 0;
        for (int k = 1; k < HT * VT; k++) begin
            step(0, 1);
            if (vb0) vb_cnt++;
            if (!vs0) vs_cnt++;
            if (fs0) fs_extra++;
        end
        chk("frame_vblank_clks", vb_cnt, 3 * HT);
        chk("frame_vsync_clks", vs_cnt, HT);
        chk("frame_no_extra_fs", fs_extra, 0);
        step(0, 1);
        chk("frame_period", fs0, 1);
        chk("frame_count_inc", fc0, fc_start + 16'd1);

        // Pause at h_pos=3, v_pos=2 for 5 clocks; frame spacing counts enabled clocks.
        en_cnt = 0;
        found = 0;
        for (int k = 0; k < LIMIT && !found; k++) begin
            step(0, 1);
            en_cnt++;
            found = v0 && (hp0 == 4'd3) && (vp0 == 4'd2);
        end
        chk("pause_wait", found, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 0);
            chk("pause_valid", v0, 0);
            chk("pause_hpos", hp0, 3);
            chk("pause_vpos", vp0, 2);
        end
        step(0, 1);
        en_cnt++;
        chk("resume_hpos", hp0, 4);
        chk("resume_valid", v0, 1);
        found = 0;
        for (int k = 0; k < LIMIT && !found; k++) begin
            step(0, 1);
            en_cnt++;
            found = fs0;
        end
        chk("resume_fs_wait", found, 1);
        chk("resume_fs_spacing", en_cnt, HT * VT);

        // Reset mid-line at h_pos=6, v_pos=1.
        found = 0;
        for (int k = 0; k < LIMIT && !found; k++) begin
            step(0, 1);
            found = v0 && (hp0 == 4'd6) && (vp0 == 4'd1);
        end
        chk("midrst_wait", found, 1);
        step(1, 1);
        chk("midrst_strobes", {v0, ls0, fs0}, 3'b000);
        chk("midrst_blank", {hb0, vb0}, 2'b11);
        chk("midrst_pos", {hp0, vp0}, 8'h00);
        chk("midrst_sync_lo_pol", {hs0, vs0}, 2'b11);
        chk("midrst_sync_hi_pol", {hs1, vs1}, 2'b00);
        chk("midrst_fc_pat", {fc0, pat0}, '0);
        step(0, 1);
        chk("post_rst_first", {v0, ls0, fs0, hp0, vp0}, {3'b111, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
